// File: rtl/booth_multiplier.sv
// Sequential radix-2 Booth multiplier: one add/subtract-and-shift step per enabled clock.
// Operands are latched once after reset; the signed product appears WIDTH+1 enabled edges later.
module booth_multiplier #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   result
);

  localparam int unsigned AW = WIDTH + 1;
  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [1:0] LOAD = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state, state_nxt;
  logic [AW-1:0]    acc, acc_nxt;
  logic [AW-1:0]    mcand, mcand_nxt;
  logic [WIDTH-1:0] q, q_nxt;
  logic             q_1, q_1_nxt;
  logic [CW-1:0]    count, count_nxt;
  logic [PW-1:0]    result_nxt;
  logic [AW-1:0]    sum;

  // State and datapath registers; reset wins over enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= LOAD;
      acc    <= '0;
      mcand  <= '0;
      q      <= '0;
      q_1    <= 1'b0;
      count  <= '0;
      result <= '0;
    end else begin
      state  <= state_nxt;
      acc    <= acc_nxt;
      mcand  <= mcand_nxt;
      q      <= q_nxt;
      q_1    <= q_1_nxt;
      count  <= count_nxt;
      result <= result_nxt;
    end
  end

  // Next-state and datapath step; everything holds unless enabled.
  always_comb begin
    state_nxt  = state;
    acc_nxt    = acc;
    mcand_nxt  = mcand;
    q_nxt      = q;
    q_1_nxt    = q_1;
    count_nxt  = count;
    result_nxt = result;
    sum        = acc;

    case (state)
      LOAD: begin
        if (en) begin
          mcand_nxt = {a[WIDTH-1], a};
          q_nxt     = b;
          q_1_nxt   = 1'b0;
          acc_nxt   = '0;
          count_nxt = CW'(WIDTH);
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (en) begin
          case ({q[0], q_1})
            2'b01:   sum = acc + mcand;
            2'b10:   sum = acc - mcand;
            default: sum = acc;
          endcase
          // Arithmetic right shift of {acc, q, q_1} with acc's sign replicated.
          acc_nxt   = {sum[AW-1], sum[AW-1:1]};
          q_nxt     = {sum[0], q[WIDTH-1:1]};
          q_1_nxt   = q[0];
          count_nxt = count - CW'(1);
          if (count == CW'(1)) begin
            result_nxt = {acc_nxt[WIDTH-1:0], q_nxt};
            state_nxt  = DONE;
          end
        end
      end
      default: begin
        state_nxt = state;
      end
    endcase
  end

endmodule

// File: tb/tb_booth_multiplier.sv
// Self-checking bench for booth_multiplier: directed spec vectors, random operands,
// and control scenarios (stall, late input change, mid-operation reset).
module tb_booth_multiplier;

  localparam int unsigned W = 32;

  logic          clk;
  logic          reset;
  logic          en;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [2*W-1:0] result;

  int n_cmp;
  int n_err;

  booth_multiplier #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .a      (a),
    .b      (b),
    .result (result)
  );

  initial clk = 1'b0;
  always #2 clk = ~clk;

  // Reference product computed with plain signed 64-bit arithmetic.
  function automatic logic [63:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx;
    longint sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    return 64'(sx * sy);
  endfunction

  // Pulse reset for one edge, then present operands with en high on the next negedge.
  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    reset = 1'b1;
    en    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    a     = x;
    b     = y;
    en    = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    a = 32'h1234_5678;
    b = 32'h0000_0003;
    reset = 1'b1;
    en = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (result !== 64'd0) begin
      n_err++;
      $display("FAIL reset_clear: got %0h want 0", result);
    end
    @(negedge clk);
    reset = 1'b0;
    en = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    n_cmp++;
    if (result !== 64'd0) begin
      n_err++;
      $display("FAIL reset_en_low_hold: got %0h want 0", result);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0]  ta [13];
    logic [W-1:0]  tb [13];
    logic [63:0]   te [13];
    ta[0]  = 32'sd553524;      tb[0]  = 32'sd840;         te[0]  = 64'sd464960160;
    ta[1]  = 32'sd553524;      tb[1]  = -32'sd259;        te[1]  = -64'sd143362716;
    ta[2]  = -32'sd259;        tb[2]  = 32'sd553524;      te[2]  = -64'sd143362716;
    ta[3]  = 32'sd1348760118;  tb[3]  = -32'sd1199060305; te[3]  = -64'sd1617244718460915990;
    ta[4]  = -32'sd1199060305; tb[4]  = 32'sd1348760118;  te[4]  = -64'sd1617244718460915990;
    ta[5]  = -32'sd259;        tb[5]  = -32'sd259;        te[5]  = 64'sd67081;
    ta[6]  = -32'sd1199060305; tb[6]  = -32'sd2005095693; te[6]  = 64'sd2404230653202766365;
    ta[7]  = 32'sd1;           tb[7]  = 32'sd1348760118;  te[7]  = 64'sd1348760118;
    ta[8]  = -32'sd1199060305; tb[8]  = 32'sd1;           te[8]  = -64'sd1199060305;
    ta[9]  = 32'sd0;           tb[9]  = 32'sd1348760118;  te[9]  = 64'sd0;
    ta[10] = 32'h8000_0000;    tb[10] = 32'h8000_0000;    te[10] = 64'h4000_0000_0000_0000;
    ta[11] = 32'h8000_0000;    tb[11] = 32'sd1;           te[11] = 64'hFFFF_FFFF_8000_0000;
    ta[12] = 32'h7FFF_FFFF;    tb[12] = 32'h8000_0000;    te[12] = 64'hC000_0000_8000_0000;
    for (int i = 0; i < 13; i++) begin
      start_op(ta[i], tb[i]);
      repeat (32) @(posedge clk);
      #1;
      n_cmp++;
      if (result !== 64'd0) begin
        n_err++;
        $display("FAIL directed%0d_edge32: got %0h want 0", i, result);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (result !== te[i]) begin
        n_err++;
        $display("FAIL directed%0d_edge33: got %0h want %0h", i, result, te[i]);
      end
      repeat (12) @(posedge clk);
      #1;
      n_cmp++;
      if (result !== te[i]) begin
        n_err++;
        $display("FAIL directed%0d_hold: got %0h want %0h", i, result, te[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [63:0]  exp;
    for (int i = 0; i < 24; i++) begin
      x = $urandom();
      y = $urandom();
      if (i == 0) y = 32'hFFFF_FFFF;
      if (i == 1) x = 32'h8000_0000;
      exp = ref_mul(x, y);
      start_op(x, y);
      repeat (33) @(posedge clk);
      #1;
      n_cmp++;
      if (result !== exp) begin
        n_err++;
        $display("FAIL random%0d a=%0h b=%0h: got %0h want %0h", i, x, y, result, exp);
      end
    end
  endtask

  task automatic test_input_change();
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [63:0]  exp;
    x = $urandom();
    y = $urandom();
    exp = ref_mul(x, y);
    start_op(x, y);
    @(posedge clk);
    @(negedge clk);
    a = ~x;
    b = y ^ 32'h5A5A_5A5A;
    repeat (32) @(posedge clk);
    #1;
    n_cmp++;
    if (result !== exp) begin
      n_err++;
      $display("FAIL input_change: got %0h want %0h", result, exp);
    end
  endtask

  task automatic test_enable_stall();
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [63:0]  exp;
    x = 32'sd553524;
    y = -32'sd259;
    exp = ref_mul(x, y);
    start_op(x, y);
    repeat (10) @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if (result !== 64'd0) begin
      n_err++;
      $display("FAIL stall_frozen: got %0h want 0", result);
    end
    @(negedge clk);
    en = 1'b1;
    repeat (22) @(posedge clk);
    #1;
    n_cmp++;
    if (result !== 64'd0) begin
      n_err++;
      $display("FAIL stall_edge37: got %0h want 0", result);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (result !== exp) begin
      n_err++;
      $display("FAIL stall_edge38: got %0h want %0h", result, exp);
    end
  endtask

  task automatic test_mid_reset();
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [63:0]  exp;
    start_op(32'sd1348760118, -32'sd1199060305);
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (result !== 64'd0) begin
      n_err++;
      $display("FAIL midreset_clear: got %0h want 0", result);
    end
    x = $urandom();
    y = $urandom();
    exp = ref_mul(x, y);
    @(negedge clk);
    reset = 1'b0;
    a = x;
    b = y;
    repeat (33) @(posedge clk);
    #1;
    n_cmp++;
    if (result !== exp) begin
      n_err++;
      $display("FAIL midreset_fresh: got %0h want %0h", result, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    en    = 1'b0;
    a     = '0;
    b     = '0;
    test_reset();
    test_directed();
    test_random();
    test_input_change();
    test_enable_stall();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
